// File: rtl/mem_req_scheduler_pkg.sv
// Shared types and constants for the iomem request scheduler.
package mem_req_scheduler_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned BLK_SIZE = 128;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = XLEN;
    localparam int unsigned DATA_W = BLK_SIZE;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(NREQ);

    localparam int unsigned REQ_DCACHE = 0;
    localparam int unsigned REQ_ICACHE = 1;
    localparam int unsigned REQ_AUX    = 2;

    // Block alignment: the low nibble of a request address is ignored.
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] wstrb;
    } sched_req_t;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [DATA_W-1:0] data;
        logic              err;
    } sched_rsp_t;

    // Round-robin pointer advance, wrapping the last requester back to 0.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] g);
        return (g == PTR_W'(NREQ - 1)) ? '0 : g + PTR_W'(1);
    endfunction

endpackage

// File: rtl/mem_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after the pointer, wrapping modulo NREQ.
module mem_req_scheduler_rr_arbiter
    import mem_req_scheduler_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_c_o
);

    logic [PTR_W-1:0] idx;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        gnt_c_o = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(ptr_i) + i) % NREQ);
            if (gnt_c_o == '0 && req_i[idx]) begin
                gnt_c_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// Three-requester scheduler (dcache, icache, aux) in front of the single
// iomem port. One transaction in flight, round-robin grant.
// Optional watchdog enabled by defining MEM_SCHED_TIMEOUT_EN.
module mem_req_scheduler
    import mem_req_scheduler_pkg::*;
`ifdef MEM_SCHED_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 1024
)
`endif
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NREQ-1:0]               req_valid_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_wdata_i,
    input  logic [NREQ-1:0][STRB_W-1:0]   req_wstrb_i,
    output logic [NREQ-1:0]               rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          iomem_valid,
    input  logic                          iomem_ready,
    output logic [ADDR_W-1:0]             iomem_addr,
    output logic [STRB_W-1:0]             iomem_wstrb,
    output logic [DATA_W-1:0]             iomem_wdata,
    input  logic [DATA_W-1:0]             iomem_rdata,
    output logic                          busy_o
);

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    sched_state_e     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  owner_q, owner_d;
    sched_req_t       lat_q, lat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]  gnt;
    logic [PTR_W-1:0] g;

    mem_req_scheduler_rr_arbiter u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_c_o (gnt)
    );

    // State, pointer, owner and request/response latches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(REQ_DCACHE);
            owner_q <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_SCHED_TIMEOUT_EN
    // Watchdog counter and error flag for the current transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // Next-state logic: grant in IDLE, wait for memory in ISSUE, pulse in RESP.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        rdata_d     = rdata_q;
        req_ready_o = '0;
        g           = '0;
`ifdef MEM_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[PTR_W'(i)]) begin
                g = PTR_W'(i);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o = gnt;
                    owner_d     = gnt;
                    lat_d.valid = 1'b1;
                    lat_d.addr  = req_addr_i[g] & ADDR_MASK;
                    lat_d.data  = req_wdata_i[g];
                    lat_d.wstrb = req_wstrb_i[g];
                    ptr_d       = ptr_next(g);
                    state_d     = ISSUE;
`ifdef MEM_SCHED_TIMEOUT_EN
                    cnt_d       = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (iomem_ready) begin
                    rdata_d = (lat_q.wstrb != '0) ? '0 : iomem_rdata;
                    state_d = RESP;
`ifdef MEM_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side and response-side outputs decoded from registered state.
    assign iomem_valid = (state_q == ISSUE) && lat_q.valid;
    assign iomem_addr  = lat_q.addr;
    assign iomem_wstrb = lat_q.wstrb;
    assign iomem_wdata = lat_q.data;
    assign rsp_valid_o = (state_q == RESP) ? owner_q : '0;
    assign rsp_rdata_o = rdata_q;
    assign busy_o      = (state_q != IDLE);
`ifdef MEM_SCHED_TIMEOUT_EN
    assign rsp_err_o   = (state_q == RESP) && err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Bench for mem_req_scheduler: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_req_scheduler;

    localparam int NR = 3;
    localparam int TO = 8;
`ifdef MEM_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [2:0][31:0]  req_addr;
    logic [2:0][127:0] req_wdata;
    logic [2:0][15:0]  req_wstrb;
    logic [2:0]        rsp_valid;
    logic [127:0]      rsp_rdata;
    logic              rsp_err;
    logic              iomem_valid;
    logic              iomem_ready;
    logic [31:0]       iomem_addr;
    logic [15:0]       iomem_wstrb;
    logic [127:0]      iomem_wdata;
    logic [127:0]      iomem_rdata;
    logic              busy;

    always #5 clk = ~clk;

`ifdef MEM_SCHED_TIMEOUT_EN
    mem_req_scheduler #(.TIMEOUT_CYC(TO)) dut (
`else
    mem_req_scheduler dut (
`endif
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_addr  (iomem_addr),
        .iomem_wstrb (iomem_wstrb),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy_o      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = idle, 1 = memory request open, 2 = response.
    bit           model_live = 1'b0;
    int           m_phase = 0;
    int           m_ptr = 0;
    int           m_owner = 0;
    int           m_cnt = 0;
    logic [31:0]  m_addr = '0;
    logic [15:0]  m_wstrb = '0;
    logic [127:0] m_wdata = '0;
    logic [127:0] m_rdata = '0;
    bit           m_err = 1'b0;
    int           exp_g = -1;
    int           acc_g = -1;
    bit           prev_rst = 1'b0;

    // Stimulus knobs.
    int           arm_pct = 0;
    int           mem_mode = 2;   // 0 random, 1 fixed latency, 2 never
    int           mem_k = 1;
    int           mem_pct = 35;
    logic [127:0] mem_fix_rdata = '0;
    int           issue_age = 0;
    bit           rst_rand_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic arm(input int i);
        req_valid[2'(i)] = 1'b1;
        req_addr[2'(i)]  = $urandom;
        req_wdata[2'(i)] = rnd128();
        req_wstrb[2'(i)] = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom);
    endtask

    // Which requester the rules say gets this cycle's grant (-1 if none).
    task automatic model_grant();
        exp_g = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (exp_g < 0 && req_valid[2'(c)]) exp_g = c;
            end
        end
    endtask

    task automatic compare_cycle();
        logic [2:0] exp_ready;
        logic [2:0] exp_rsp;
        exp_ready = (exp_g >= 0) ? 3'(1 << exp_g) : 3'b000;
        exp_rsp   = (m_phase == 2) ? 3'(1 << m_owner) : 3'b000;
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("busy", 128'(busy), 128'(m_phase != 0));
        chk("iomem_valid", 128'(iomem_valid), 128'(m_phase == 1));
        if (m_phase == 1) begin
            chk("iomem_addr", 128'(iomem_addr), 128'(m_addr));
            chk("iomem_wstrb", 128'(iomem_wstrb), 128'(m_wstrb));
            chk("iomem_wdata", iomem_wdata, m_wdata);
        end
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_rsp));
        if (m_phase == 2) chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 128'(rsp_err), 128'((m_phase == 2) && m_err));
    endtask

    task automatic model_update();
        prev_rst = rst;
        acc_g    = rst ? -1 : exp_g;
        if (rst) begin
            model_live = 1'b1;
            m_phase = 0;
            m_ptr   = 0;
            m_rdata = '0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: if (exp_g >= 0) begin
                    m_owner = exp_g;
                    m_ptr   = (exp_g + 1) % NR;
                    m_addr  = req_addr[2'(exp_g)] & 32'hFFFF_FFF0;
                    m_wstrb = req_wstrb[2'(exp_g)];
                    m_wdata = req_wdata[2'(exp_g)];
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: if (iomem_ready) begin
                    m_rdata = (m_wstrb != '0) ? '0 : iomem_rdata;
                    m_err   = 1'b0;
                    m_phase = 2;
                end else if (TO_EN && m_cnt == TO - 1) begin
                    m_rdata = '0;
                    m_err   = 1'b1;
                    m_phase = 2;
                end else begin
                    m_cnt++;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic drive();
        if (prev_rst) req_valid = '0;
        else if (acc_g >= 0) req_valid[2'(acc_g)] = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (!req_valid[2'(i)] && int'($urandom_range(99)) < arm_pct) arm(i);
        end
        if (rst_rand_en) rst = ($urandom_range(399) == 0);
        issue_age = (m_phase == 1) ? issue_age + 1 : 0;
        case (mem_mode)
            0: begin
                iomem_ready = (int'($urandom_range(99)) < mem_pct);
                iomem_rdata = rnd128();
            end
            1: begin
                iomem_ready = (m_phase == 1) && (issue_age == mem_k);
                iomem_rdata = mem_fix_rdata;
            end
            default: begin
                iomem_ready = 1'b0;
                iomem_rdata = rnd128();
            end
        endcase
    endtask

    // One clock: compare at the falling edge, advance, drive after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_grant();
        if (model_live) compare_cycle();
        model_update();
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst_rand_en = 1'b0;
        arm_pct = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int order[6];
    int n_ord;
    logic [31:0]  bp_addr;
    logic [15:0]  bp_wstrb;
    logic [127:0] bp_wdata;
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        iomem_ready = 1'b0;
        iomem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values.
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_iomem_valid", 128'(iomem_valid), 128'(0));
        chk("rst_iomem_addr", 128'(iomem_addr), 128'(0));
        chk("rst_iomem_wstrb", 128'(iomem_wstrb), 128'(0));
        chk("rst_iomem_wdata", iomem_wdata, 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_rdata", rsp_rdata, 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));

        // Single icache read, memory answers at k=2.
        mem_mode = 1;
        mem_k = 2;
        mem_fix_rdata = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0014;
        req_wstrb[1] = 16'h0;
        req_wdata[1] = rnd128();
        #1;
        chk("rd_accept", 128'(req_ready), 128'(3'b010));
        tick();
        chk("rd_iomem_valid", 128'(iomem_valid), 128'(1));
        chk("rd_iomem_addr", 128'(iomem_addr), 128'(32'h8000_0010));
        chk("rd_iomem_wstrb", 128'(iomem_wstrb), 128'(0));
        tick();
        chk("rd_rsp_early", 128'(rsp_valid), 128'(0));
        tick();
        chk("rd_rsp_valid", 128'(rsp_valid), 128'(3'b010));
        chk("rd_rsp_rdata", rsp_rdata, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
        tick();

        // dcache write: strobes and data pass through, read data forced to 0.
        mem_k = 1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_1238;
        req_wstrb[0] = 16'h00F0;
        req_wdata[0] = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        #1;
        chk("wr_accept", 128'(req_ready), 128'(3'b001));
        tick();
        chk("wr_iomem_addr", 128'(iomem_addr), 128'(32'h0000_1230));
        chk("wr_iomem_wstrb", 128'(iomem_wstrb), 128'(16'h00F0));
        chk("wr_iomem_wdata", iomem_wdata, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        tick();
        chk("wr_rsp_valid", 128'(rsp_valid), 128'(3'b001));
        chk("wr_rsp_rdata", rsp_rdata, 128'(0));
        tick();

        // Fairness: all three held valid from reset.
        do_reset();
        mem_mode = 1;
        mem_k = 1;
        arm_pct = 100;
        n_ord = 0;
        for (int i = 0; i < 6; i++) order[i] = 7;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (req_ready != '0 && n_ord < 6) begin
                for (int b = 0; b < NR; b++) if (req_ready[2'(b)]) order[n_ord] = b;
                n_ord++;
            end
        end
        for (int i = 0; i < 6; i++) chk("fair_order", 128'(order[i]), 128'(exp_order[i]));
        arm_pct = 0;
        for (int t = 0; t < 4; t++) tick();

`ifdef MEM_SCHED_TIMEOUT_EN
        // Watchdog: no answer for TO cycles gives an error response.
        do_reset();
        mem_mode = 2;
        arm(2);
        req_wstrb[2] = 16'h0;
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("to_iomem_valid", 128'(iomem_valid), 128'(1));
            chk("to_rsp_quiet", 128'(rsp_valid), 128'(0));
            tick();
        end
        chk("to_rsp_valid", 128'(rsp_valid), 128'(3'b100));
        chk("to_rsp_err", 128'(rsp_err), 128'(1));
        chk("to_rsp_rdata", rsp_rdata, 128'(0));
        chk("to_iomem_drop", 128'(iomem_valid), 128'(0));
        tick();

        // Ready on the last allowed cycle wins over the watchdog.
        mem_mode = 1;
        mem_k = TO;
        mem_fix_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        arm(0);
        req_wstrb[0] = 16'h0;
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("to2_iomem_valid", 128'(iomem_valid), 128'(1));
            tick();
        end
        chk("to2_rsp_valid", 128'(rsp_valid), 128'(3'b001));
        chk("to2_rsp_err", 128'(rsp_err), 128'(0));
        chk("to2_rsp_rdata", rsp_rdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        tick();
`else
        // Back-pressure: memory silent for 50 cycles.
        do_reset();
        mem_mode = 2;
        for (int i = 0; i < NR; i++) arm(i);
        bp_addr  = req_addr[0] & 32'hFFFF_FFF0;
        bp_wstrb = req_wstrb[0];
        bp_wdata = req_wdata[0];
        tick();
        for (int t = 0; t < 50; t++) begin
            chk("bp_iomem_valid", 128'(iomem_valid), 128'(1));
            chk("bp_req_ready", 128'(req_ready), 128'(0));
            chk("bp_iomem_addr", 128'(iomem_addr), 128'(bp_addr));
            chk("bp_iomem_wstrb", 128'(iomem_wstrb), 128'(bp_wstrb));
            chk("bp_iomem_wdata", iomem_wdata, bp_wdata);
            tick();
        end
        mem_mode = 0;
        for (int t = 0; t < 20; t++) tick();
`endif

        // Reset in the third ISSUE cycle discards the transaction.
        do_reset();
        mem_mode = 2;
        arm(1);
        tick();
        tick();
        tick();
        chk("rip_iomem_valid", 128'(iomem_valid), 128'(1));
        rst = 1'b1;
        tick();
        chk("rip_iomem_drop", 128'(iomem_valid), 128'(0));
        chk("rip_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rip_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        tick();
        chk("rip_rsp_after", 128'(rsp_valid), 128'(0));
        for (int i = 0; i < NR; i++) arm(i);
        #1;
        chk("rip_next_grant", 128'(req_ready), 128'(3'b001));
        mem_mode = 0;
        for (int t = 0; t < 10; t++) tick();

        // Randomized traffic with occasional resets.
        do_reset();
        mem_mode = 0;
        mem_pct = 35;
        arm_pct = 30;
        rst_rand_en = 1'b1;
        for (int t = 0; t < 3000; t++) tick();
        arm_pct = 100;
        mem_pct = 60;
        for (int t = 0; t < 1000; t++) tick();
        rst_rand_en = 1'b0;
        rst = 1'b0;
        arm_pct = 0;
        for (int t = 0; t < 40; t++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_req_scheduler.md
Name: mem_req_scheduler

Overview:
- Three-requester scheduler in front of the single iomem port: I-cache refill, D-cache refill/writeback, and an auxiliary port (boot loader / debug DMA).
- Round-robin arbitration; one outstanding transaction at a time; optional watchdog.
- Sits between the cache-side request structs and the cpu-level iomem_* pins.

Parameters:
- NREQ, 3, number of requesters; index 0 = dcache, 1 = icache, 2 = aux.
- ADDR_W, XLEN (32), address width.
- DATA_W, BLK_SIZE (128), block width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester accept pulse
- req_addr_i  in  NREQ×ADDR_W  block-aligned address; bits [3:0] ignored
- req_wdata_i  in  NREQ×DATA_W  write data
- req_wstrb_i  in  NREQ×16  byte strobes; 0 = read
- rsp_valid_o  out  NREQ  one-cycle response pulse to the owning requester
- rsp_rdata_o  out  DATA_W  read data, shared by all requesters and qualified by rsp_valid_o
- rsp_err_o  out  1  response carries a timeout error
- iomem_valid  out  1  memory request valid
- iomem_ready  in  1  memory completion pulse; rdata valid in the same cycle
- iomem_addr  out  ADDR_W  memory address
- iomem_wstrb  out  16  memory strobes
- iomem_wdata  out  DATA_W  memory write data
- iomem_rdata  in  DATA_W  memory read data
- busy_o  out  1  transaction in flight

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0 (dcache first).
- States: IDLE, ISSUE, RESP.

IDLE:
- If any req_valid_i is set, grant the first valid requester at or after the pointer (wrapping modulo NREQ).
- Same cycle: pulse req_ready_o[g] for one cycle, latch addr (with [3:0] forced to 0), wdata, wstrb and g.
- Next state ISSUE.
- Pointer becomes (g+1) mod NREQ, wrapping 2→0.

ISSUE:
- iomem_valid = 1; iomem_addr, iomem_wstrb and iomem_wdata come from the latch and stay stable until iomem_ready.
- On iomem_ready: capture rdata, forced to 0 when wstrb ≠ 0; next state RESP.
- iomem_ready seen in IDLE or RESP is ignored.

RESP:
- rsp_valid_o[g] = 1 for exactly one cycle; next state IDLE.
- No new grant in this cycle.
- Minimum accept-to-accept spacing is 3 cycles when memory answers in the first ISSUE cycle.

Latency and handshake rules:
- Latency: accept at cycle N → iomem_valid from N+1 → iomem_ready at N+k (k ≥ 1) → rsp_valid at N+k+1.
- req_ready_o is only ever asserted in IDLE, and only one bit at a time.
- Requesters hold valid and fields stable until ready; a valid dropped before ready is simply not granted.
- busy_o = (state ≠ IDLE).
- A requester re-asserting immediately after its response waits behind any other pending requester (round-robin fairness).
- Worst-case wait for any requester: NREQ−1 transactions.

Reset in flight:
- Reset mid-ISSUE drops iomem_valid at the next edge.
- The transaction is discarded and no rsp_valid is issued.
- Requesters are reset by the same rst_i.

Optional Feature:
- Macro: MEM_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ISSUE and increments every ISSUE cycle.
  - When it reaches TIMEOUT_CYC without iomem_ready, iomem_valid drops and the block enters RESP with rsp_err_o = 1 and rdata = 0.
  - rsp_err_o is 0 on all other responses.
  - An iomem_ready arriving in the same cycle as the timeout wins: normal response, no error.
- Without the macro: no counter, rsp_err_o tied to 0, ISSUE waits indefinitely.

Decomposition:
- tcore_param additions:
  - sched_state_e {IDLE, ISSUE, RESP}
  - sched_req_t {valid, addr, data, wstrb}
  - sched_rsp_t {valid, ready, data, err}
  - localparams REQ_DCACHE = 0, REQ_ICACHE = 1, REQ_AUX = 2
- Sub-module rr_arbiter: NREQ-wide request vector and pointer in, one-hot grant out, purely combinational.
- The pointer register stays in mem_req_scheduler.

Test Plan:
- Single read: icache req addr 0x8000_0014 → iomem_addr 0x8000_0010, wstrb 0; memory answers at k=2 with rdata 0xDEAD…BEEF → rsp_valid_o = 3'b010 at accept+3, rsp_rdata_o = 0xDEAD…BEEF.
- Write: dcache wstrb 16'h00F0, wdata pattern P → iomem_wstrb 16'h00F0, iomem_wdata P, rsp_rdata_o = 0.
- Fairness: all three requesters held valid from reset → grant order 0,1,2,0,1,2 over six transactions, with no bit of req_ready_o asserted twice before the others are served.
- Back-pressure: iomem_ready withheld 50 cycles → iomem_valid, addr, wstrb and wdata constant throughout; req_ready_o stays 0 for all requesters.
- Reset mid-ISSUE: rst_i asserted on cycle 3 of ISSUE → iomem_valid = 0 next cycle; no rsp_valid_o; next grant goes to dcache.
- MEM_SCHED_TIMEOUT_EN, TIMEOUT_CYC = 8, iomem_ready never asserted → iomem_valid high for 8 cycles, then rsp_valid_o with rsp_err_o = 1 and rdata 0; a second run with ready arriving on the 8th cycle → rsp_err_o = 0.
